// File: rtl/earom_arbiter.sv
// Arbiter sharing one single-port high-score RAM between the game core and the HPS.
// Each granted request takes IDLE -> ACCESS -> DONE; ack appears in DONE, two cycles after the grant.
module earom_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,

    input  logic          hps_req,
    input  logic          hps_we,
    input  logic [AW-1:0] hps_addr,
    input  logic [DW-1:0] hps_din,
    output logic [DW-1:0] hps_dout,
    output logic          hps_ack,
    input  logic          hps_lock,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,

    output logic          dirty,
    input  logic          hps_clr_dirty,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_HPS = 1'b1;

    state_t        state_q;
    logic          owner_q;
    logic          we_q;
    logic          last_owner_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic          mem_we_q;
    logic          cpu_ack_q;
    logic          hps_ack_q;
    logic [DW-1:0] cpu_dout_q;
    logic [DW-1:0] hps_dout_q;
    logic          dirty_q;

    logic          cpu_elig;
    logic          hps_elig;
    logic          grant_any;
    logic          grant_owner;
    logic          gnt_we;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_din;
    logic          rd_done_cpu;
    logic          rd_done_hps;

    assign cpu_elig  = cpu_req && !hps_lock;
    assign hps_elig  = hps_req;
    assign grant_any = cpu_elig || hps_elig;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_owner = OWN_CPU;
        if (cpu_elig && hps_elig) begin
            grant_owner = ~last_owner_q;
        end else if (hps_elig) begin
            grant_owner = OWN_HPS;
        end
    end

    always_comb begin
        gnt_we   = cpu_we;
        gnt_addr = cpu_addr;
        gnt_din  = cpu_din;
        if (grant_owner == OWN_HPS) begin
            gnt_we   = hps_we;
            gnt_addr = hps_addr;
            gnt_din  = hps_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            last_owner_q <= OWN_HPS;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            hps_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            hps_dout_q   <= '0;
            dirty_q      <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            hps_ack_q <= 1'b0;
            mem_we_q  <= 1'b0;
            // A CPU write in ACCESS below overrides this clear.
            if (hps_clr_dirty) begin
                dirty_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        owner_q      <= grant_owner;
                        last_owner_q <= grant_owner;
                        we_q         <= gnt_we;
                        mem_addr_q   <= gnt_addr;
                        mem_din_q    <= gnt_din;
                        mem_we_q     <= gnt_we;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner_q == OWN_CPU) begin
                        cpu_ack_q <= 1'b1;
                        if (we_q) begin
                            dirty_q <= 1'b1;
                        end
                    end else begin
                        hps_ack_q <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_dout_q <= mem_dout;
                        end else begin
                            hps_dout_q <= mem_dout;
                        end
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM data only arrives in DONE, so it is forwarded there and held from the next cycle on.
    assign rd_done_cpu = (state_q == DONE) && !we_q && (owner_q == OWN_CPU);
    assign rd_done_hps = (state_q == DONE) && !we_q && (owner_q == OWN_HPS);

    assign cpu_dout = rd_done_cpu ? mem_dout : cpu_dout_q;
    assign hps_dout = rd_done_hps ? mem_dout : hps_dout_q;
    assign cpu_ack  = cpu_ack_q;
    assign hps_ack  = hps_ack_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign dirty    = dirty_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_earom_arbiter.sv
// Bench for earom_arbiter: directed requests, expected acks queued in grant order and
// checked by an independent monitor against a behavioural RAM.
module tb_earom_arbiter;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_we;
    logic [5:0] cpu_addr;
    logic [7:0] cpu_din, cpu_dout;
    logic       cpu_ack;
    logic       hps_req, hps_we;
    logic [5:0] hps_addr;
    logic [7:0] hps_din, hps_dout;
    logic       hps_ack, hps_lock;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       dirty, hps_clr_dirty, busy;

    earom_arbiter #(.AW(6), .DW(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .hps_req(hps_req), .hps_we(hps_we), .hps_addr(hps_addr), .hps_din(hps_din),
        .hps_dout(hps_dout), .hps_ack(hps_ack), .hps_lock(hps_lock),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .dirty(dirty), .hps_clr_dirty(hps_clr_dirty), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM: read data one cycle after the address.
    logic [7:0] ram [64];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       owner;   // 0 = CPU, 1 = HPS
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always @(negedge clk_sys) begin
        if (cpu_ack || hps_ack) begin
            check("ack_onehot", 32'(cpu_ack & hps_ack), 32'h0);
            if (q.size() == 0) begin
                check("unexpected_ack", 32'(hps_ack), 32'h2);
            end else begin
                mon_e = q.pop_front();
                check("ack_owner", 32'(hps_ack), 32'(mon_e.owner));
                if (mon_e.rd)
                    check(mon_e.owner ? "hps_rd_data" : "cpu_rd_data",
                          32'(mon_e.owner ? hps_dout : cpu_dout), 32'(mon_e.data));
            end
        end
        if (mem_we && !busy) check("mem_we_idle", 32'(mem_we), 32'h0);
    end

    function automatic exp_t E(input logic owner, input logic rd, input logic [7:0] data);
        exp_t e;
        e.owner = owner; e.rd = rd; e.data = data;
        return e;
    endfunction

    task automatic cpu_xact(input logic we, input logic [5:0] a, input logic [7:0] d, output int ac);
        bit got = 0;
        @(negedge clk_sys);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        ac = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin got = 1; ac = cyc; break; end
        end
        if (!got) check("cpu_ack_timeout", 32'h0, 32'h1);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
    endtask

    task automatic hps_xact(input logic we, input logic [5:0] a, input logic [7:0] d, output int ac);
        bit got = 0;
        @(negedge clk_sys);
        hps_req = 1'b1; hps_we = we; hps_addr = a; hps_din = d;
        ac = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (hps_ack) begin got = 1; ac = cyc; break; end
        end
        if (!got) check("hps_ack_timeout", 32'h0, 32'h1);
        @(posedge clk_sys); #1;
        hps_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c1, c2, drop_cyc;

    initial begin
        reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        hps_req = 0; hps_we = 0; hps_addr = 0; hps_din = 0; hps_lock = 0; hps_clr_dirty = 0;

        // Reset values
        repeat (3) @(negedge clk_sys);
        check("rst_acks",  32'({cpu_ack, hps_ack}), 32'h0);
        check("rst_mem",   32'({mem_we, mem_addr, mem_din}), 32'h0);
        check("rst_dout",  32'({cpu_dout, hps_dout}), 32'h0);
        check("rst_dirty", 32'(dirty), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        reset_n = 1'b1;

        // CPU write 0x05 <= 0xA7 with cycle-exact checks
        @(negedge clk_sys);
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h05; cpu_din = 8'hA7;
        q.push_back(E(0, 0, 8'h00));
        @(negedge clk_sys);
        check("wr_mem_we",   32'(mem_we), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h05);
        check("wr_mem_din",  32'(mem_din), 32'hA7);
        check("wr_busy",     32'(busy), 32'h1);
        check("wr_no_early_ack", 32'(cpu_ack), 32'h0);
        @(negedge clk_sys);
        check("wr_ack_n2",   32'(cpu_ack), 32'h1);
        check("wr_dirty",    32'(dirty), 32'h1);
        check("wr_mem_we_off", 32'(mem_we), 32'h0);
        @(posedge clk_sys); #1;
        cpu_req = 0;

        // CPU read sets cpu_dout, then HPS read of 0x05
        q.push_back(E(0, 0, 8'h00)); cpu_xact(1, 6'h3C, 8'h5E, c1);
        q.push_back(E(0, 1, 8'h5E)); cpu_xact(0, 6'h3C, 8'h00, c1);
        q.push_back(E(1, 1, 8'hA7)); hps_xact(0, 6'h05, 8'h00, c2);
        check("cpu_dout_held",  32'(cpu_dout), 32'h5E);
        check("dirty_after_hps_rd", 32'(dirty), 32'h1);
        q.push_back(E(0, 0, 8'h00)); cpu_xact(1, 6'h06, 8'h99, c1);
        check("cpu_dout_kept_on_wr", 32'(cpu_dout), 32'h5E);
        check("hps_dout_held",  32'(hps_dout), 32'hA7);

        // Fresh reset, then simultaneous requests
        @(negedge clk_sys); reset_n = 0;
        @(negedge clk_sys); reset_n = 1;
        q.push_back(E(0, 0, 8'h00)); q.push_back(E(1, 0, 8'h00));
        fork
            cpu_xact(1, 6'h10, 8'h11, c1);
            hps_xact(1, 6'h11, 8'h22, c2);
        join
        check("tie1_cpu_first", 32'(c1 < c2), 32'h1);
        q.push_back(E(0, 1, 8'h22)); q.push_back(E(1, 1, 8'h11));
        fork
            cpu_xact(0, 6'h11, 8'h00, c1);
            hps_xact(0, 6'h10, 8'h00, c2);
        join
        check("tie2_cpu_first", 32'(c1 < c2), 32'h1);
        q.push_back(E(0, 0, 8'h00)); cpu_xact(1, 6'h12, 8'h33, c1);
        q.push_back(E(1, 1, 8'h33)); q.push_back(E(0, 1, 8'h33));
        fork
            cpu_xact(0, 6'h12, 8'h00, c1);
            hps_xact(0, 6'h12, 8'h00, c2);
        join
        check("tie3_hps_first", 32'(c2 < c1), 32'h1);

        // HPS lock: CPU held off while HPS writes three times
        @(negedge clk_sys); hps_lock = 1;
        q.push_back(E(1, 0, 8'h00)); q.push_back(E(1, 0, 8'h00));
        q.push_back(E(1, 0, 8'h00)); q.push_back(E(0, 0, 8'h00));
        fork
            cpu_xact(1, 6'h20, 8'h44, c1);
            begin
                hps_xact(1, 6'h21, 8'h01, c2);
                hps_xact(1, 6'h22, 8'h02, c2);
                hps_xact(1, 6'h23, 8'h03, c2);
                repeat (2) @(negedge clk_sys);
                hps_lock = 0;
                drop_cyc = cyc;
            end
        join
        check("lock_cpu_grant_latency", 32'(c1 - drop_cyc), 32'h2);

        // Lock rising while a CPU write is in ACCESS: the write still completes
        @(negedge clk_sys);
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h24; cpu_din = 8'h55;
        q.push_back(E(0, 0, 8'h00));
        @(posedge clk_sys); #1; hps_lock = 1;
        @(negedge clk_sys);
        check("lock_mid_mem_we", 32'(mem_we), 32'h1);
        @(negedge clk_sys);
        check("lock_mid_ack", 32'(cpu_ack), 32'h1);
        @(posedge clk_sys); #1; cpu_req = 0; hps_lock = 0;
        q.push_back(E(1, 1, 8'h55)); hps_xact(0, 6'h24, 8'h00, c2);

        // Dirty flag
        @(negedge clk_sys); hps_clr_dirty = 1;
        @(negedge clk_sys); hps_clr_dirty = 0;
        check("dirty_lone_clr", 32'(dirty), 32'h0);
        q.push_back(E(1, 0, 8'h00)); hps_xact(1, 6'h30, 8'h77, c2);
        check("dirty_hps_wr", 32'(dirty), 32'h0);
        @(negedge clk_sys);
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h31; cpu_din = 8'h66;
        q.push_back(E(0, 0, 8'h00));
        @(negedge clk_sys);
        hps_clr_dirty = 1;
        check("coinc_in_access", 32'(mem_we), 32'h1);
        @(negedge clk_sys);
        hps_clr_dirty = 0;
        check("dirty_set_wins", 32'(dirty), 32'h1);
        @(posedge clk_sys); #1; cpu_req = 0;

        // Reset during ACCESS of a CPU read: no ack, outputs back to reset values
        @(negedge clk_sys);
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'h31;
        @(posedge clk_sys); #1; reset_n = 0;
        @(negedge clk_sys);
        check("rst_mid_busy_before", 32'(busy), 32'h1);
        @(negedge clk_sys);
        cpu_req = 0;
        check("rst_mid_acks", 32'({cpu_ack, hps_ack}), 32'h0);
        check("rst_mid_mem",  32'({mem_we, mem_addr, mem_din}), 32'h0);
        check("rst_mid_dout", 32'({cpu_dout, hps_dout}), 32'h0);
        check("rst_mid_dirty_busy", 32'({dirty, busy}), 32'h0);
        @(negedge clk_sys); reset_n = 1;
        repeat (5) @(negedge clk_sys);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
